// File: rtl/mem_ctrl_pkg.sv
// Shared types and default opcodes for the load/store sequencer.
package mem_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StMar,
    StStData,
    StStMdr,
    StStWait,
    StLdWait,
    StLdMdr,
    StLdBus,
    StLdWb,
    StDone,
    StErr
  } state_e;

  localparam logic [3:0] OPC_LOAD_DEF  = 4'h3;
  localparam logic [3:0] OPC_STORE_DEF = 4'h4;

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot enable decoder; index 0 drives the MSB.
module reg_onehot_dec #(
  parameter int unsigned FIELD_W  = 6,
  parameter int unsigned NUM_REGS = 6
) (
  input  logic [FIELD_W-1:0]  idx,
  output logic [NUM_REGS-1:0] onehot,
  output logic                valid
);

  // Out-of-range indices yield an all-zero vector and valid=0.
  always_comb begin
    valid = (32'(idx) < NUM_REGS);
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      onehot[NUM_REGS-1-i] = (32'(idx) == i);
    end
  end

endmodule

// File: rtl/mem_ctrl_fsm.sv
// Load/store sequencer: decodes LOAD/STORE and drives datapath strobes as Moore outputs.
module mem_ctrl_fsm
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned         INSTR_W   = 16,
  parameter int unsigned         OPC_W     = 4,
  parameter int unsigned         FIELD_W   = 6,
  parameter int unsigned         NUM_REGS  = 6,
  parameter int unsigned         TIMEOUT   = 255,
  parameter logic [OPC_W-1:0]    OPC_LOAD  = OPC_W'(OPC_LOAD_DEF),
  parameter logic [OPC_W-1:0]    OPC_STORE = OPC_W'(OPC_STORE_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic                mfc,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                mem_en,
  output logic                mar_in,
  output logic                mdr_write_en,
  output logic                mdr_read_en,
  output logic                mdr_out,
  output logic                rw,
  output logic                pc_inc,
  output logic [NUM_REGS-1:0] rx_out,
  output logic [NUM_REGS-1:0] rx_in
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OPC_W-1:0]     opc_q;
  logic [FIELD_W-1:0]   p1_q, p2_q;

  logic [OPC_W-1:0]     opc_in;
  logic [FIELD_W-1:0]   p1_in, p2_in, p1_sel, p2_sel;
  logic [NUM_REGS-1:0]  p1_oh, p2_oh;
  logic                 p1_ok, p2_ok, accept, timeout, in_wait;

  assign opc_in  = instruction[INSTR_W-1 -: OPC_W];
  assign p1_in   = instruction[2*FIELD_W-1 -: FIELD_W];
  assign p2_in   = instruction[FIELD_W-1:0];
  assign accept  = start && (state_q == StIdle);
  assign in_wait = (state_q == StStWait) || (state_q == StLdWait);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  // In IDLE the decoders validate the incoming fields; afterwards they see the latched copy.
  assign p1_sel = (state_q == StIdle) ? p1_in : p1_q;
  assign p2_sel = (state_q == StIdle) ? p2_in : p2_q;

  reg_onehot_dec #(.FIELD_W(FIELD_W), .NUM_REGS(NUM_REGS)) u_dec_p1 (
    .idx    (p1_sel),
    .onehot (p1_oh),
    .valid  (p1_ok)
  );

  reg_onehot_dec #(.FIELD_W(FIELD_W), .NUM_REGS(NUM_REGS)) u_dec_p2 (
    .idx    (p2_sel),
    .onehot (p2_oh),
    .valid  (p2_ok)
  );

  // State, wait counter and instruction fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opc_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        opc_q <= opc_in;
        p1_q  <= p1_in;
        p2_q  <= p2_in;
      end
    end
  end

  // Next-state and wait-counter logic; mfc wins over timeout on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (((opc_in == OPC_LOAD) || (opc_in == OPC_STORE)) && p1_ok && p2_ok)
                    ? StAddr : StErr;
        end
      end
      StAddr:   state_d = StMar;
      StMar:    state_d = (opc_q == OPC_LOAD) ? StLdWait : StStData;
      StStData: state_d = StStMdr;
      StStMdr:  state_d = StStWait;
      StStWait: begin
        if (mfc)          state_d = StDone;
        else if (timeout) state_d = StErr;
      end
      StLdWait: begin
        if (mfc)          state_d = StLdMdr;
        else if (timeout) state_d = StErr;
      end
      StLdMdr:  state_d = StLdBus;
      StLdBus:  state_d = StLdWb;
      StLdWb:   state_d = StDone;
      StDone:   state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    cnt_d = (in_wait && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;
  end

  // Moore output decode.
  always_comb begin
    busy         = (state_q != StIdle);
    done         = 1'b0;
    err          = 1'b0;
    mem_en       = 1'b0;
    mar_in       = 1'b0;
    mdr_write_en = 1'b0;
    mdr_read_en  = 1'b0;
    mdr_out      = 1'b0;
    rw           = 1'b0;
    pc_inc       = 1'b0;
    rx_out       = '0;
    rx_in        = '0;
    unique case (state_q)
      StAddr:   begin pc_inc = 1'b1; rx_out = p2_oh; end
      StMar:    begin mar_in = 1'b1; rx_out = p2_oh; end
      StStData: rx_out = p1_oh;
      StStMdr:  begin mdr_write_en = 1'b1; rx_out = p1_oh; end
      StStWait: mem_en = 1'b1;
      StLdWait: begin mem_en = 1'b1; rw = 1'b1; end
      StLdMdr:  begin mem_en = 1'b1; rw = 1'b1; mdr_read_en = 1'b1; end
      StLdBus:  begin mdr_out = 1'b1; rw = 1'b1; end
      StLdWb:   begin mdr_out = 1'b1; rw = 1'b1; rx_in = p1_oh; end
      StDone:   done = 1'b1;
      StErr:    begin done = 1'b1; err = 1'b1; end
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Randomized bench for mem_ctrl_fsm against a per-transaction expected output trace.
module tb_mem_ctrl_fsm;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, mfc;
  logic [15:0] instruction;
  logic        busy, done, err, mem_en, mar_in, mdr_write_en, mdr_read_en, mdr_out, rw, pc_inc;
  logic [5:0]  rx_out, rx_in;
  logic [21:0] obs;

  // Flag order: busy done err mem_en mar_in mdr_we mdr_re mdr_out rw pc_inc
  localparam logic [9:0] F_BUSY = 10'b1000000000;
  localparam logic [9:0] F_DONE = 10'b0100000000;
  localparam logic [9:0] F_ERR  = 10'b0010000000;
  localparam logic [9:0] F_MEM  = 10'b0001000000;
  localparam logic [9:0] F_MAR  = 10'b0000100000;
  localparam logic [9:0] F_MDRW = 10'b0000010000;
  localparam logic [9:0] F_MDRR = 10'b0000001000;
  localparam logic [9:0] F_MDRO = 10'b0000000100;
  localparam logic [9:0] F_RW   = 10'b0000000010;
  localparam logic [9:0] F_PC   = 10'b0000000001;

  logic [21:0] exp_q[$];
  int          ws;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_ctrl_fsm #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .instruction  (instruction),
    .mfc          (mfc),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mem_en       (mem_en),
    .mar_in       (mar_in),
    .mdr_write_en (mdr_write_en),
    .mdr_read_en  (mdr_read_en),
    .mdr_out      (mdr_out),
    .rw           (rw),
    .pc_inc       (pc_inc),
    .rx_out       (rx_out),
    .rx_in        (rx_in)
  );

  assign obs = {busy, done, err, mem_en, mar_in, mdr_write_en, mdr_read_en, mdr_out, rw, pc_inc,
                rx_out, rx_in};

  task automatic check_val(input string tag, input logic [21:0] got, input logic [21:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %06h want %06h", tag, got, want);
    end
  endtask

  function automatic logic [21:0] mk(input logic [9:0] f, input logic [5:0] ro,
                                     input logic [5:0] ri);
    return {f, ro, ri};
  endfunction

  function automatic logic [5:0] oh(input int i);
    logic [5:0] one = 6'd1;
    return one << (5 - i);
  endfunction

  // Expected outputs for cycles c1..cN after the accepting edge (cN is DONE or ERR).
  task automatic build(input logic [15:0] ins, input int d);
    int  op, p1, p2, w;
    bit  ld;
    op = int'(ins[15:12]);
    p1 = int'(ins[11:6]);
    p2 = int'(ins[5:0]);
    exp_q.delete();
    ws = 1000;
    if (!((op == 3 || op == 4) && p1 < 6 && p2 < 6)) begin
      exp_q.push_back(mk(F_BUSY | F_DONE | F_ERR, 6'd0, 6'd0));
      return;
    end
    ld = (op == 3);
    ws = ld ? 3 : 5;
    exp_q.push_back(mk(F_BUSY | F_PC, oh(p2), 6'd0));
    exp_q.push_back(mk(F_BUSY | F_MAR, oh(p2), 6'd0));
    if (!ld) begin
      exp_q.push_back(mk(F_BUSY, oh(p1), 6'd0));
      exp_q.push_back(mk(F_BUSY | F_MDRW, oh(p1), 6'd0));
    end
    w = (d < int'(TMO)) ? d + 1 : int'(TMO);
    repeat (w) exp_q.push_back(mk(F_BUSY | F_MEM | (ld ? F_RW : 10'd0), 6'd0, 6'd0));
    if (d >= int'(TMO)) begin
      exp_q.push_back(mk(F_BUSY | F_DONE | F_ERR, 6'd0, 6'd0));
    end else begin
      if (ld) begin
        exp_q.push_back(mk(F_BUSY | F_MEM | F_RW | F_MDRR, 6'd0, 6'd0));
        exp_q.push_back(mk(F_BUSY | F_MDRO | F_RW, 6'd0, 6'd0));
        exp_q.push_back(mk(F_BUSY | F_MDRO | F_RW, 6'd0, oh(p1)));
      end
      exp_q.push_back(mk(F_BUSY | F_DONE, 6'd0, 6'd0));
    end
  endtask

  // Called at a negedge while idle; returns at the negedge of the trailing IDLE cycle.
  // d = wait cycles before mfc rises; hold keeps start high throughout.
  task automatic run_txn(input logic [15:0] ins, input int d, input bit hold, input int id);
    int n;
    build(ins, d);
    n = exp_q.size();
    start = 1'b1;
    instruction = ins;
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      check_val($sformatf("txn%0d_c%0d", id, c), obs, exp_q[c-1]);
      if (c >= ws && c < ws + d) mfc = 1'b0;
      else if (c == ws + d)      mfc = 1'b1;
      else                       mfc = 1'($urandom);
      start = hold ? 1'b1 : 1'($urandom);
      instruction = 16'($urandom);
    end
    @(negedge clk);
    check_val($sformatf("txn%0d_idle", id), obs, 22'd0);
    start = 1'b0;
    mfc = 1'b0;
  endtask

  initial begin
    logic [15:0] ins;
    int          r, d;
    rst_n = 1'b0;
    start = 1'b0;
    mfc = 1'b0;
    instruction = '0;
    #3;
    check_val("reset", obs, 22'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("reset_idle", obs, 22'd0);

    run_txn(16'h3085, 0, 1'b0, 0);   // plain load
    run_txn(16'h4043, 3, 1'b0, 1);   // store, mfc late by 3
    run_txn(16'h3087, 0, 1'b0, 2);   // invalid param2
    run_txn(16'h5000, 0, 1'b0, 3);   // illegal opcode
    run_txn(16'h3085, 99, 1'b0, 4);  // load timeout
    run_txn(16'h4043, 3, 1'b0, 5);   // store, mfc on last allowed cycle
    run_txn(16'h3085, 1, 1'b1, 6);   // start held high across two loads
    start = 1'b1;
    run_txn(16'h3085, 0, 1'b1, 7);

    // Reset asserted while in LD_BUS.
    build(16'h3085, 0);
    start = 1'b1;
    instruction = 16'h3085;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check_val($sformatf("rst_txn_c%0d", c), obs, exp_q[c-1]);
      start = 1'($urandom);
      mfc = (c == 3);
    end
    #1 rst_n = 1'b0;
    #1 check_val("rst_async", obs, 22'd0);
    start = 1'b0;
    mfc = 1'b0;
    @(negedge clk);
    check_val("rst_hold", obs, 22'd0);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_val("rst_post", obs, 22'd0);
    end
    run_txn(16'h3085, 0, 1'b0, 8);

    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 9));
      ins[15:12] = (r < 4) ? 4'h3 : (r < 8) ? 4'h4 : 4'($urandom_range(0, 15));
      ins[11:6] = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63))
                                               : 6'($urandom_range(0, 5));
      ins[5:0]  = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63))
                                               : 6'($urandom_range(0, 5));
      d = int'($urandom_range(0, 5));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_val("gap_idle", obs, 22'd0);
      end
      run_txn(ins, d, ($urandom_range(0, 3) == 0), 100 + t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_fsm.md
# mem_ctrl_fsm

Parametrised load/store sequencer for the microcontroller datapath, and the successor to the fixed 6-register memory FSM. It decodes LOAD and STORE instructions and drives the register-file, MAR, MDR and memory control strobes. Compared with the fixed FSM it adds:
- configurable instruction, field and register-count widths;
- an explicit start/busy/done handshake;
- a bounded MFC wait with a timeout error;
- error termination for illegal opcodes and out-of-range register fields.

## Interface
Parameters:
- INSTR_W, 16, instruction width; must equal OPC_W + 2*FIELD_W
- OPC_W, 4, opcode field width (top bits)
- FIELD_W, 6, width of param1 (data register) and param2 (address register) fields
- NUM_REGS, 6, number of general registers = width of rx_out/rx_in
- TIMEOUT, 255, maximum number of wait cycles without MFC before abort; must be ≥1
- OPC_LOAD, 4'h3, load opcode
- OPC_STORE, 4'h4, store opcode

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- instruction  in  INSTR_W  sampled on the accepting edge
- mfc  in  1  memory-function-complete from memory
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, on abort
- mem_en, mar_in, mdr_write_en, mdr_read_en, mdr_out, rw, pc_inc  out  1 each  datapath strobes (rw=1 read)
- rx_out, rx_in  out  NUM_REGS  one-hot register bus-drive / load enables

## Operation
- Field layout: opcode = instruction[INSTR_W-1 -: OPC_W]; param1 = next FIELD_W bits; param2 = low FIELD_W bits. All three are latched at accept and are not re-read afterwards.
- Register mapping: register index i maps to one-hot bit NUM_REGS-1-i, so index 0 drives the MSB. An index ≥ NUM_REGS is invalid.
- Outputs are Moore outputs, decoded from the registered state. Any strobe not listed for a state is 0.
- States and their outputs:
  - IDLE: all outputs 0.
  - ADDR: pc_inc=1; rx_out=onehot(param2).
  - MAR: mar_in=1; rx_out=onehot(param2).
  - ST_DATA: rx_out=onehot(param1).
  - ST_MDR: mdr_write_en=1; rx_out=onehot(param1).
  - ST_WAIT: mem_en=1; rw=0.
  - LD_WAIT: mem_en=1; rw=1.
  - LD_MDR: mem_en=1; rw=1; mdr_read_en=1.
  - LD_BUS: mdr_out=1; rw=1.
  - LD_WB: mdr_out=1; rw=1; rx_in=onehot(param1).
  - DONE: done=1.
  - ERR: done=1; err=1.
- Transitions:
  - IDLE→ADDR on start, when the opcode is LOAD/STORE and both fields are valid.
  - IDLE→ERR on start with any other opcode, or with an invalid field. No strobe or pc_inc is issued in this case.
  - ADDR→MAR.
  - MAR→LD_WAIT for LOAD; MAR→ST_DATA for STORE.
  - Store path: ST_DATA→ST_MDR→ST_WAIT.
  - ST_WAIT→DONE when mfc=1.
  - LD_WAIT→LD_MDR when mfc=1.
  - Load path: LD_MDR→LD_BUS→LD_WB→DONE.
  - Either wait state→ERR when mfc is still 0 after TIMEOUT consecutive wait cycles.
  - DONE→IDLE; ERR→IDLE.
- Wait counter: width $clog2(TIMEOUT+1). It clears on entry to a wait state and increments each cycle the FSM stays in the wait state. mfc takes priority over the timeout on the same edge.
- start outside IDLE is ignored; it is neither queued nor counted.
- Reset: state = IDLE, counter = 0, latched fields = 0, every output 0. Reset asserted mid-transaction aborts immediately with no done pulse.

## Timing
- Edge 0 is the edge on which start is accepted.
- LOAD with mfc high on the first wait cycle: ADDR c1, MAR c2, LD_WAIT c3, LD_MDR c4, LD_BUS c5, LD_WB c6, done c7. Latency is 7 cycles plus any extra wait cycles.
- STORE with mfc high on the first wait cycle: ADDR c1, MAR c2, ST_DATA c3, ST_MDR c4, ST_WAIT c5, done c6.
- Illegal request: err and done in c1; busy returns low in c2.
- Timeout: ERR occurs TIMEOUT cycles after entering the wait state; mem_en deasserts on the same edge.
- Back-to-back: a new start is accepted no earlier than the edge that ends the first IDLE cycle after DONE/ERR.

## Structure
- Package mem_ctrl_pkg holds:
  - the state enum (IDLE, ADDR, MAR, ST_DATA, ST_MDR, ST_WAIT, LD_WAIT, LD_MDR, LD_BUS, LD_WB, DONE, ERR);
  - default opcode constants OPC_LOAD_DEF and OPC_STORE_DEF.
- Sub-module reg_onehot_dec (parameters FIELD_W, NUM_REGS) converts an index to a one-hot vector plus a valid flag. It is instantiated twice, once for param1 and once for param2.

## Test plan
- LOAD 0x3085 (R2 ← mem[R5]), mfc high at c3:
  - rx_out=6'b000001 in c1–c2; pc_inc only in c1.
  - mdr_read_en in c4; rx_in=6'b001000 in c6; done in c7; err=0.
- STORE 0x4043 (mem[R3] ← R1), mfc delayed 3 cycles:
  - rx_out=6'b000100 in c1–c2, then 6'b010000 in c3–c4.
  - mem_en with rw=0 for 4 cycles; done in c9.
- Invalid register 0x3087 (param2=7) and illegal opcode 0x5000: err=done=1 in c1; pc_inc, mem_en and rx_* stay 0 throughout.
- TIMEOUT=4, LOAD with mfc held 0: ERR in c7 (c3 plus 4); mem_en low from c7; busy low from c8.
- start held high continuously across two LOADs: the second is accepted only after IDLE is re-entered; start pulses during busy have no effect.
- rst_n pulsed low in LD_BUS: all outputs 0 immediately, no done pulse, then a clean LOAD completes normally.
